// File: rtl/io_switch_led_responder_pkg.sv
// Shared definitions for the memory-mapped switch/LED IO responder:
// IO window base, register offsets, STATUS bit positions and the address
// decoder used by the responder top level.
package io_switch_led_responder_pkg;

  localparam int ISA_WIDTH = 32;

  // Upper 24 address bits that select the IO window.
  localparam logic [23:0] IO_BASE = 24'hFFFFFC;

  // Register offsets inside the IO window (byte offsets, word aligned).
  localparam logic [7:0] OFF_LED  = 8'h60;
  localparam logic [7:0] OFF_SW   = 8'h70;
  localparam logic [7:0] OFF_EDGE = 8'h74;
  localparam logic [7:0] OFF_STAT = 8'h78;

  // STATUS register bit positions.
  localparam int STAT_PEND_BIT = 0;
  localparam int STAT_ERR_BIT  = 1;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LED,
    SEL_SW,
    SEL_EDGE,
    SEL_STAT
  } reg_sel_t;

  // Decode a word address (byte lane bits already dropped) to a register.
  function automatic reg_sel_t decode_addr(input logic [ISA_WIDTH-1:2] word_addr);
    reg_sel_t sel;
    sel = SEL_NONE;
    if (word_addr[ISA_WIDTH-1:8] == IO_BASE) begin
      if (word_addr[7:2] == OFF_LED[7:2])       sel = SEL_LED;
      else if (word_addr[7:2] == OFF_SW[7:2])   sel = SEL_SW;
      else if (word_addr[7:2] == OFF_EDGE[7:2]) sel = SEL_EDGE;
      else if (word_addr[7:2] == OFF_STAT[7:2]) sel = SEL_STAT;
    end
    return sel;
  endfunction

endpackage

// File: rtl/io_switch_led_responder_switch_debouncer.sv
// Switch conditioning: 2-flop synchronizer, periodic sampling tick and
// two-sample agreement debounce. The first sample after reset loads the
// debounced value directly so switches already on at reset produce no
// change. 'change' pulses for one cycle with the bits that just flipped.
module switch_debouncer #(
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] switches,
  output logic [SW_WIDTH-1:0] debounced,
  output logic [SW_WIDTH-1:0] change
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] sync_meta;
  logic [SW_WIDTH-1:0] sync_out;
  logic [SW_WIDTH-1:0] sample_prev;
  logic [SW_WIDTH-1:0] agree_diff;
  logic [CNT_W-1:0]    tick_cnt;
  logic                tick;
  logic                first_done;

  assign tick = (tick_cnt == CNT_LAST);

  // Bits whose last two samples agree and differ from the debounced value.
  assign agree_diff = ~(sync_out ^ sample_prev) & (sync_out ^ debounced);

  // Two-flop synchronizer for the asynchronous switch pins.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= switches;
      sync_out  <= sync_meta;
    end
  end

  // Free-running sample tick counter, wrapping at DEBOUNCE_CYCLES-1.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Sample on each tick and update debounced bits on two agreeing samples.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sample_prev <= '0;
      debounced   <= '0;
      change      <= '0;
      first_done  <= 1'b0;
    end else begin
      change <= '0;
      if (tick) begin
        sample_prev <= sync_out;
        if (!first_done) begin
          debounced  <= sync_out;
          first_done <= 1'b1;
        end else begin
          debounced <= debounced ^ agree_diff;
          change    <= agree_diff;
        end
      end
    end
  end

endmodule

// File: rtl/io_switch_led_responder.sv
// Memory-mapped IO responder for LEDs and debounced switches.
// Registers: LED_DATA (0x60), SW_DATA (0x70), SW_EDGE read-to-clear (0x74),
// STATUS (0x78). Optional sticky access-error flag is enabled by defining
// the macro IO_RESP_ERR_EN; without it STATUS bit1 reads 0 and no error
// storage exists.
module io_switch_led_responder
  import io_switch_led_responder_pkg::*;
#(
  parameter int SW_WIDTH        = 16,
  parameter int LED_WIDTH       = 16,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 io_read,
  input  logic                 io_write,
  input  logic [ISA_WIDTH-1:0] addr,
  input  logic [ISA_WIDTH-1:0] wdata,
  output logic [ISA_WIDTH-1:0] rdata,
  output logic                 io_hit,
  input  logic [SW_WIDTH-1:0]  switches,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 sw_pending
);

  logic                rst_meta;
  logic                rst_local;
  reg_sel_t            sel;
  logic                led_wr;
  logic [SW_WIDTH-1:0] sw_debounced;
  logic [SW_WIDTH-1:0] sw_change;
  logic [SW_WIDTH-1:0] sw_edge;
  logic [SW_WIDTH-1:0] edge_clr;
  logic [SW_WIDTH-1:0] edge_next;
  logic                err_flag;
  logic                unused_bits;

  assign unused_bits = ^{addr[1:0], wdata};

  // Reset bridge: asserts asynchronously, releases on a clock edge.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rst_meta  <= 1'b0;
      rst_local <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_local <= rst_meta;
    end
  end

  assign sel    = decode_addr(addr[ISA_WIDTH-1:2]);
  assign io_hit = (sel != SEL_NONE);
  assign led_wr = io_write && (sel == SEL_LED);

  // A simultaneous write suppresses the read-to-clear side effect; only
  // the bits actually returned by the read are cleared.
  assign edge_clr  = (io_read && !io_write && (sel == SEL_EDGE)) ? sw_edge : '0;
  assign edge_next = (sw_edge & ~edge_clr) | sw_change;

  switch_debouncer #(
    .SW_WIDTH       (SW_WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock    (clock),
    .rst      (rst_local),
    .switches (switches),
    .debounced(sw_debounced),
    .change   (sw_change)
  );

  // LED output register, loaded by writes to LED_DATA.
  always_ff @(posedge clock or negedge rst_local) begin
    if (!rst_local) begin
      leds <= '0;
    end else if (led_wr) begin
      leds <= wdata[LED_WIDTH-1:0];
    end
  end

  // Sticky change flags with set-wins-over-clear, plus the pending summary.
  always_ff @(posedge clock or negedge rst_local) begin
    if (!rst_local) begin
      sw_edge    <= '0;
      sw_pending <= 1'b0;
    end else begin
      sw_edge    <= edge_next;
      sw_pending <= |edge_next;
    end
  end

`ifdef IO_RESP_ERR_EN
  logic err_set;
  logic err_clr;

  assign err_set = ((io_read || io_write) && (sel == SEL_NONE)) ||
                   (io_write && ((sel == SEL_SW) || (sel == SEL_EDGE)));
  assign err_clr = io_write && (sel == SEL_STAT) && wdata[STAT_ERR_BIT];

  // Sticky access-error flag, cleared by writing 1 to STATUS bit1.
  always_ff @(posedge clock or negedge rst_local) begin
    if (!rst_local) begin
      err_flag <= 1'b0;
    end else if (err_set) begin
      err_flag <= 1'b1;
    end else if (err_clr) begin
      err_flag <= 1'b0;
    end
  end
`else
  assign err_flag = 1'b0;
`endif

  // Combinational read mux, zero-extended; unmapped addresses read 0.
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_LED:  rdata[LED_WIDTH-1:0] = leds;
      SEL_SW:   rdata[SW_WIDTH-1:0]  = sw_debounced;
      SEL_EDGE: rdata[SW_WIDTH-1:0]  = sw_edge;
      SEL_STAT: begin
        rdata[STAT_PEND_BIT] = sw_pending;
        rdata[STAT_ERR_BIT]  = err_flag;
      end
      default:  rdata = '0;
    endcase
  end

endmodule

// File: doc/io_switch_led_responder.md
Name: io_switch_led_responder

Overview:
- Memory-mapped IO responder on the CPU side of the MemOrIO path.
- Accepts single-cycle io_read/io_write strobes from the core and decodes the IO address.
- Owns the LED output register.
- Synchronizes and debounces the board switches, and keeps sticky per-bit change flags with an interrupt-style pending output.

Parameters:
- SW_WIDTH, 16, number of switch inputs.
- LED_WIDTH, 16, number of LED outputs.
- DEBOUNCE_CYCLES, 20000, clock cycles between switch samples (about 1 ms at the CPU clock).

Ports:
- clock  input  1  CPU clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- io_read  input  1  read strobe, one cycle per access.
- io_write  input  1  write strobe, one cycle per access.
- addr  input  32  byte address from the ALU result.
- wdata  input  32  write data (register rt value).
- rdata  output  32  read data, combinational from registered state.
- io_hit  output  1  addr decodes to a mapped register.
- switches  input  SW_WIDTH  raw asynchronous switch pins.
- leds  output  LED_WIDTH  LED drive, registered.
- sw_pending  output  1  OR of all SW_EDGE bits.

Behaviour:
- Reset: asynchronous assertion and synchronous deassertion. Clears to 0: leds, the synchronizer flops, the sample counter, the debounced value, the previous sample, SW_EDGE, the first-sample flag and the error flag. rdata and io_hit follow addr combinationally.
- Address map (addr[31:8] must equal 24'hFFFFFC, otherwise unmapped; addr[1:0] ignored):
  - 0x60 LED_DATA, read/write, low LED_WIDTH bits.
  - 0x70 SW_DATA, read-only, debounced switches.
  - 0x74 SW_EDGE, read-to-clear.
  - 0x78 STATUS, read-only: bit0 = sw_pending, bit1 = err (see Optional Feature).
- Read data: zero-extended to 32 bits. Unmapped reads return 0 and io_hit=0.
- Latency:
  - rdata is valid in the same cycle as io_read.
  - A write to LED_DATA updates leds on the next rising edge.
  - The read-to-clear side effect applies at that same edge.
- Writes to read-only registers or unmapped addresses are ignored and leave state unchanged.
- io_read and io_write high together: the write is performed, the read side effect is suppressed, and rdata is still driven.
- Switch path:
  - 2-flop synchronizer per bit.
  - The tick counter counts 0..DEBOUNCE_CYCLES-1 and wraps. Each wrap samples the synchronized value into the sample register.
  - A debounced bit updates only when two consecutive samples agree and differ from the current debounced value.
- First sample after reset: loads the debounced value directly with no edge flags set, so switches already on at reset raise no events.
- SW_EDGE: a bit sets when its debounced value changes, in either direction.
- SW_EDGE read clear: clears only the bits returned in that read. A bit that sets in the same cycle as the clear remains set (set wins).
- sw_pending is registered, derived as the OR of SW_EDGE.
- Reset asserted mid-debounce: all in-progress samples are discarded and the first-sample rule applies again.

Optional Feature:
- Macro: IO_RESP_ERR_EN.
- Defined:
  - A sticky err flag sets on any io_read or io_write to an unmapped address, or on a write to a read-only register.
  - err reads as STATUS bit1.
  - err is cleared by a write of 1 to STATUS bit1 (the only writable STATUS bit).
- Not defined: STATUS bit1 reads 0, writes to STATUS are ignored, and no err storage is synthesized.

Decomposition:
- Shared definitions package/header, alongside ISA_WIDTH: IO base constant 24'hFFFFFC, register offsets LED=8'h60, SW=8'h70, EDGE=8'h74, STAT=8'h78, and STATUS bit indices.
- One sub-module, switch_debouncer: parameters SW_WIDTH and DEBOUNCE_CYCLES. It contains the synchronizer, tick counter, two-sample agreement logic and first-sample flag, and outputs the debounced vector plus a one-cycle change mask.

Test Plan:
- LED write/read: io_write=1, addr=FFFFFC60, wdata=0000A5A5. Expect leds=A5A5 on the next edge; io_read to the same address returns 0000A5A5 with io_hit=1.
- Reset-on switches: switches=0x0003 held through reset release (DEBOUNCE_CYCLES=4 in the bench). Expect SW_DATA=0x0003 after the first sample, with SW_EDGE=0 and sw_pending=0.
- Bounce rejection: bit 4 toggles each cycle for 3 tick periods, then stays 1. Expect the debounced bit 4 to rise only after two agreeing samples, SW_EDGE=0x0010, sw_pending=1.
- Clear race: read SW_EDGE (value 0x0010) in the cycle where bit 5 newly changes. Expect SW_EDGE=0x0020 afterwards and sw_pending to stay 1.
- Unmapped and read-only accesses: write FFFFFC70 and write 00001000. Expect leds and SW_DATA unchanged and rdata=0 for the unmapped address. With IO_RESP_ERR_EN, STATUS=0x2; after writing 0x2 to FFFFFC78, STATUS=0x0.
- Reset mid-operation: drop rst while bit 6 is half-debounced with SW_EDGE=0x0001. Expect leds=0 and SW_EDGE=0 immediately, and no edge flags after the first post-reset sample.
